// File: rtl/adder_2bit_seq_ctrl.sv
// Digit-serial WIDTH-bit adder sequencer: drives a shared 2-bit adder one digit per clock,
// least-significant digit first, and chains its carry-out back into carry-in.
//
// state | meaning
// IDLE  | waiting for start; adder inputs held at zero
// RUN   | one 2-bit digit per cycle, digit index k = 0 .. N-1
// DONE  | result presented with res_valid until res_ready
module adder_2bit_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   output logic             busy,
   output logic [1:0]       add_a,
   output logic [1:0]       add_b,
   output logic             add_cin,
   input  logic [1:0]       add_sum,
   input  logic             add_count,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_valid,
   input  logic             res_ready
);

   localparam int N  = WIDTH / 2;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [KW-1:0]    k;
   logic [KW-1:0]    k_nxt;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH-1:0] sum_nxt;
   logic             carry_reg;

   assign k_nxt = k + 1'b1;

   // Current digit from the adder merged into the partial sum.
   always_comb begin
      sum_nxt = sum_reg;
      sum_nxt[{k, 1'b0} +: 2] = add_sum;
   end

   // Adder inputs are registered one edge ahead so they line up with digit k in RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         k         <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         busy      <= 1'b0;
         add_a     <= 2'b00;
         add_b     <= 2'b00;
         add_cin   <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  carry_reg <= op_cin;
                  sum_reg   <= '0;
                  k         <= '0;
                  add_a     <= op_a[1:0];
                  add_b     <= op_b[1:0];
                  add_cin   <= op_cin;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               sum_reg   <= sum_nxt;
               carry_reg <= add_count;
               if (k == K_LAST) begin
                  k         <= '0;
                  add_a     <= 2'b00;
                  add_b     <= 2'b00;
                  add_cin   <= 1'b0;
                  res_sum   <= sum_nxt;
                  res_cout  <= add_count;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  k       <= k_nxt;
                  add_a   <= a_reg[{k_nxt, 1'b0} +: 2];
                  add_b   <= b_reg[{k_nxt, 1'b0} +: 2];
                  add_cin <= add_count;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adder_2bit_seq_ctrl.sv
// Scoreboard bench: WIDTH=8 instance with random and directed additions, plus an
// exhaustive WIDTH=2 instance; both drive a behavioural 2-bit adder.
module tb_adder_2bit_seq_ctrl;
   localparam int W  = 8;
   localparam int N  = W / 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: event observed, required none (t=%0t)", name, $time);
   endtask

   // ---------------- WIDTH=8 instance ----------------
   logic         start8, op_cin8, busy8, add_cin8, add_count8, res_cout8, res_valid8, res_ready8;
   logic [W-1:0] op_a8, op_b8, res_sum8;
   logic [1:0]   add_a8, add_b8, add_sum8;
   logic         hold8 = 1'b0;

   assign {add_count8, add_sum8} = {1'b0, add_a8} + {1'b0, add_b8} + {2'b00, add_cin8};

   adder_2bit_seq_ctrl #(.WIDTH(W)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op_a(op_a8), .op_b(op_b8), .op_cin(op_cin8),
      .busy(busy8), .add_a(add_a8), .add_b(add_b8), .add_cin(add_cin8),
      .add_sum(add_sum8), .add_count(add_count8), .res_sum(res_sum8), .res_cout(res_cout8),
      .res_valid(res_valid8), .res_ready(res_ready8)
   );

   // ---------------- WIDTH=2 instance ----------------
   logic       start2, op_cin2, busy2, add_cin2, add_count2, res_cout2, res_valid2, res_ready2;
   logic [1:0] op_a2, op_b2, res_sum2, add_a2, add_b2, add_sum2;

   assign {add_count2, add_sum2} = {1'b0, add_a2} + {1'b0, add_b2} + {2'b00, add_cin2};

   adder_2bit_seq_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2), .op_cin(op_cin2),
      .busy(busy2), .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
      .add_sum(add_sum2), .add_count(add_count2), .res_sum(res_sum2), .res_cout(res_cout2),
      .res_valid(res_valid2), .res_ready(res_ready2)
   );

   typedef struct {
      logic [W:0] res;
      int         t;
   } exp_t;

   exp_t q8[$];
   exp_t q2[$];

   // Consumer readiness changes just after the rising edge, so it is stable at sampling.
   initial begin
      res_ready8 = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         res_ready8 = hold8 ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   // Monitor for WIDTH=8: latency, hold stability and result against the queue.
   logic       pv8 = 1'b0, pr8 = 1'b0;
   logic [W:0] pres8 = '0;
   always @(negedge clk) begin
      if (!rst) begin
         if (pv8 && !pr8) begin
            check("hold_valid8", res_valid8, 1);
            check("hold_value8", {res_cout8, res_sum8}, pres8);
         end
         if (res_valid8 && !pv8) begin
            if (q8.size() == 0) fail("spurious_valid8");
            else check("latency8", cyc - q8[0].t, N + 1);
         end
         if (res_valid8 && res_ready8 && q8.size() != 0) begin
            check("result8", {res_cout8, res_sum8}, q8[0].res);
            void'(q8.pop_front());
         end
      end
      pv8   = res_valid8;
      pr8   = res_ready8;
      pres8 = {res_cout8, res_sum8};
   end

   // Monitor for WIDTH=2.
   logic pv2 = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (res_valid2 && !pv2) begin
            if (q2.size() == 0) fail("spurious_valid2");
            else check("latency2", cyc - q2[0].t, 2);
         end
         if (res_valid2 && res_ready2 && q2.size() != 0) begin
            check("result2", {res_cout2, res_sum2}, q2[0].res);
            void'(q2.pop_front());
         end
      end
      pv2 = res_valid2;
   end

   task automatic wait_idle8();
      int g = 0;
      while (busy8 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (busy8) fail("idle_timeout8");
   endtask

   task automatic poke8();
      start8  = 1'b1;
      op_a8   = W'($urandom);
      op_b8   = W'($urandom);
      op_cin8 = 1'($urandom);
   endtask

   // Issue one addition, check the digit stream, optionally disturb start and hold the result.
   task automatic run8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input bit poke, input bit hold);
      int ai, bi, mask, g;
      wait_idle8();
      hold8   = hold;
      start8  = 1'b1;
      op_a8   = a;
      op_b8   = b;
      op_cin8 = c;
      q8.push_back('{res: {1'b0, a} + {1'b0, b} + {8'd0, c}, t: cyc});
      @(negedge clk);
      start8 = 1'b0;
      ai = int'(a);
      bi = int'(b);
      for (int j = 0; j < N; j++) begin
         mask = (1 << (2 * j)) - 1;
         check("digit_a", add_a8, (ai >> (2 * j)) & 3);
         check("digit_b", add_b8, (bi >> (2 * j)) & 3);
         check("digit_cin", add_cin8, ((ai & mask) + (bi & mask) + int'(c)) >> (2 * j));
         check("busy_run", busy8, 1);
         if (poke) poke8();
         @(negedge clk);
         start8 = 1'b0;
      end
      check("done_add_zero", {add_a8, add_b8, add_cin8}, 0);
      check("done_busy", busy8, 1);
      if (hold) begin
         for (int i = 0; i < 5; i++) begin
            check("held_valid", res_valid8, 1);
            check("held_result", {res_cout8, res_sum8}, {1'b0, a} + {1'b0, b} + {8'd0, c});
            poke8();
            @(negedge clk);
         end
         hold8 = 1'b0;
      end
      if (poke) begin
         g = 0;
         while (res_valid8 && g < 100) begin
            poke8();
            @(negedge clk);
            g++;
         end
         start8 = 1'b0;
      end
   endtask

   initial begin
      int g;
      rst = 1'b1;
      start8 = 1'b0; op_a8 = '0; op_b8 = '0; op_cin8 = 1'b0;
      start2 = 1'b0; op_a2 = '0; op_b2 = '0; op_cin2 = 1'b0;
      res_ready2 = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", busy8, 0);
      check("rst_valid", res_valid8, 0);
      check("rst_res", {res_cout8, res_sum8}, 0);
      check("rst_add", {add_a8, add_b8, add_cin8}, 0);
      rst = 1'b0;
      @(negedge clk);

      run8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
      run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      run8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
      run8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      run8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
      run8(8'h3C, 8'h99, 1'b0, 1'b1, 1'b1);

      // Reset mid-RUN: outputs clear asynchronously and the pending result is dropped.
      wait_idle8();
      g = 0;
      while (q8.size() != 0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (q8.size() != 0) fail("drain_before_rst");
      start8 = 1'b1; op_a8 = 8'h77; op_b8 = 8'h66; op_cin8 = 1'b1;
      q8.push_back('{res: 9'h0DE, t: cyc});
      @(negedge clk);
      start8 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_busy", busy8, 0);
      check("arst_valid", res_valid8, 0);
      check("arst_res", {res_cout8, res_sum8}, 0);
      check("arst_add", {add_a8, add_b8, add_cin8}, 0);
      void'(q8.pop_back());
      @(negedge clk);
      rst = 1'b0;
      repeat (N + 2) @(negedge clk);
      check("no_valid_after_rst", res_valid8, 0);
      run8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++)
         run8(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'b0);

      g = 0;
      while (q8.size() != 0 && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (q8.size() != 0) fail("drain8");

      // WIDTH=2: exhaustive operands, one RUN cycle per addition.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 2; c++) begin
               g = 0;
               while (busy2 && g < 50) begin
                  @(negedge clk);
                  g++;
               end
               if (busy2) fail("idle_timeout2");
               start2 = 1'b1; op_a2 = 2'(a); op_b2 = 2'(b); op_cin2 = 1'(c);
               q2.push_back('{res: 9'(a + b + c), t: cyc});
               @(negedge clk);
               start2 = 1'b0;
               check("digit2", {add_a2, add_b2, add_cin2}, (a << 3) | (b << 1) | c);
            end
      g = 0;
      while (q2.size() != 0 && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (q2.size() != 0) fail("drain2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
